// File: rtl/game_ctrl.sv
// Round controller for the memory game: start/run/timeout/done sequencing,
// countdown of remaining seconds, score latching and high-score tracking.
module game_ctrl #(
  parameter int unsigned GAME_SECONDS = 30,
  parameter int unsigned ACK_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startIn,
  input  logic       secTick,
  input  logic       endGame,
  input  logic [3:0] scoreIn,
  output logic       gameEnable,
  output logic       gameTimeout,
  output logic [5:0] timeLeft,
  output logic [3:0] finalScore,
  output logic [3:0] highScore,
  output logic       newHigh,
  output logic [3:0] gameCount
);

  localparam int unsigned TW = 6;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {IDLE, RUN, TIMEOUT, DONE} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SW-1:0] final_q, final_d;
  logic [SW-1:0] high_q, high_d;
  logic          new_high_q, new_high_d;
  logic [CW-1:0] count_q, count_d;
  logic          enable_q, enable_d;
  logic          timeout_q, timeout_d;
  logic          enter_done;

  // State and output registers; enable/timeout are decoded from next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      time_q     <= TW'(GAME_SECONDS);
      wait_q     <= '0;
      final_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      count_q    <= '0;
      enable_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      wait_q     <= wait_d;
      final_q    <= final_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      count_q    <= count_d;
      enable_q   <= enable_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    wait_d     = wait_q;
    final_d    = final_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    count_d    = count_q;
    enter_done = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (startIn) begin
          state_d    = RUN;
          time_d     = TW'(GAME_SECONDS);
          new_high_d = 1'b0;
        end
      end
      RUN: begin
        // endGame wins over a coincident secTick
        if (endGame) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end else if (secTick) begin
          if (time_q <= TW'(1)) begin
            time_d  = '0;
            wait_d  = '0;
            state_d = TIMEOUT;
          end else begin
            time_d = time_q - TW'(1);
          end
        end
      end
      TIMEOUT: begin
        if (endGame || (wait_q == WW'(ACK_CYCLES - 1))) begin
          state_d    = DONE;
          enter_done = 1'b1;
          wait_d     = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_done) begin
      final_d = scoreIn;
      count_d = count_q + CW'(1);
      if (scoreIn > high_q) begin
        high_d     = scoreIn;
        new_high_d = 1'b1;
      end else begin
        new_high_d = 1'b0;
      end
    end

    enable_d  = (state_d == RUN) || (state_d == TIMEOUT);
    timeout_d = (state_d == TIMEOUT);
  end

  assign gameEnable  = enable_q;
  assign gameTimeout = timeout_q;
  assign timeLeft    = time_q;
  assign finalScore  = final_q;
  assign highScore   = high_q;
  assign newHigh     = new_high_q;
  assign gameCount   = count_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters (30 s round, 8-clock watchdog).
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       startIn;
  logic       secTick;
  logic       endGame;
  logic [3:0] scoreIn;
  logic       gameEnable;
  logic       gameTimeout;
  logic [5:0] timeLeft;
  logic [3:0] finalScore;
  logic [3:0] highScore;
  logic       newHigh;
  logic [3:0] gameCount;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  game_ctrl #(.GAME_SECONDS(30), .ACK_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .startIn    (startIn),
    .secTick    (secTick),
    .endGame    (endGame),
    .scoreIn    (scoreIn),
    .gameEnable (gameEnable),
    .gameTimeout(gameTimeout),
    .timeLeft   (timeLeft),
    .finalScore (finalScore),
    .highScore  (highScore),
    .newHigh    (newHigh),
    .gameCount  (gameCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    startIn = 1'b1;
    step();
    startIn = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      secTick = 1'b1;
      step();
      secTick = 1'b0;
    end
  endtask

  task automatic pulse_end();
    endGame = 1'b1;
    step();
    endGame = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; startIn = 1'b0; secTick = 1'b0; endGame = 1'b0; scoreIn = 4'd0;
    #12;
    check("rst_enable",  32'(gameEnable), 0);
    check("rst_timeout", 32'(gameTimeout), 0);
    check("rst_time",    32'(timeLeft), 30);
    check("rst_final",   32'(finalScore), 0);
    check("rst_high",    32'(highScore), 0);
    check("rst_count",   32'(gameCount), 0);
    #8 rst = 1'b1;

    // IDLE ignores endGame and secTick
    endGame = 1'b1; secTick = 1'b1;
    step();
    endGame = 1'b0; secTick = 1'b0;
    check("idle_count", 32'(gameCount), 0);
    check("idle_time",  32'(timeLeft), 30);
    check("idle_en",    32'(gameEnable), 0);

    // Normal end: 5 ticks, score 7
    scoreIn = 4'd7;
    pulse_start();
    check("start_en",   32'(gameEnable), 1);
    check("start_time", 32'(timeLeft), 30);
    ticks(5);
    check("run_time25", 32'(timeLeft), 25);
    pulse_start();
    check("run_ignore_start", 32'(timeLeft), 25);
    pulse_end();
    check("n_en",    32'(gameEnable), 0);
    check("n_time",  32'(timeLeft), 25);
    check("n_final", 32'(finalScore), 7);
    check("n_high",  32'(highScore), 7);
    check("n_new",   32'(newHigh), 1);
    check("n_count", 32'(gameCount), 1);
    pulse_end();
    check("done_ignore_end", 32'(gameCount), 1);

    // Timeout then late endGame, lower score
    scoreIn = 4'd2;
    pulse_start();
    check("t_new_clr", 32'(newHigh), 0);
    check("t_reload",  32'(timeLeft), 30);
    ticks(29);
    check("t_time1", 32'(timeLeft), 1);
    check("t_to_pre", 32'(gameTimeout), 0);
    ticks(1);
    check("t_to",    32'(gameTimeout), 1);
    check("t_time0", 32'(timeLeft), 0);
    check("t_en",    32'(gameEnable), 1);
    ticks(1);
    check("t_no_underflow", 32'(timeLeft), 0);
    pulse_end();
    check("t_to_off", 32'(gameTimeout), 0);
    check("t_final",  32'(finalScore), 2);
    check("t_high",   32'(highScore), 7);
    check("t_new",    32'(newHigh), 0);
    check("t_count",  32'(gameCount), 2);

    // Watchdog: no endGame after timeout
    scoreIn = 4'd4;
    pulse_start();
    ticks(30);
    check("w_to", 32'(gameTimeout), 1);
    for (int i = 0; i < 7; i++) step();
    check("w_to_7", 32'(gameTimeout), 1);
    check("w_count_7", 32'(gameCount), 2);
    step();
    check("w_to_8",  32'(gameTimeout), 0);
    check("w_en_8",  32'(gameEnable), 0);
    check("w_final", 32'(finalScore), 4);
    check("w_count", 32'(gameCount), 3);

    // Collision at timeLeft=1
    scoreIn = 4'd9;
    pulse_start();
    ticks(29);
    secTick = 1'b1; endGame = 1'b1;
    step();
    secTick = 1'b0; endGame = 1'b0;
    check("c_to",    32'(gameTimeout), 0);
    check("c_time",  32'(timeLeft), 1);
    check("c_high",  32'(highScore), 9);
    check("c_new",   32'(newHigh), 1);
    check("c_count", 32'(gameCount), 4);

    // Reset mid-round is immediate and discards the round
    pulse_start();
    ticks(2);
    check("r_time_pre", 32'(timeLeft), 28);
    rst = 1'b0;
    #1;
    check("r_en",    32'(gameEnable), 0);
    check("r_time",  32'(timeLeft), 30);
    check("r_high",  32'(highScore), 0);
    check("r_final", 32'(finalScore), 0);
    check("r_count", 32'(gameCount), 0);
    #2 rst = 1'b1;
    startIn = 1'b1;
    #1;
    check("r_no_early", 32'(gameEnable), 0);
    step();
    startIn = 1'b0;
    check("r_restart", 32'(gameEnable), 1);
    pulse_end();
    check("r_round_count", 32'(gameCount), 1);

    // 16 rounds from reset with score 15
    rst = 1'b0;
    #2 rst = 1'b1;
    scoreIn = 4'd15;
    for (int r = 1; r <= 16; r++) begin
      pulse_start();
      pulse_end();
      if (r == 1) begin
        check("wr_new1",  32'(newHigh), 1);
        check("wr_high1", 32'(highScore), 15);
      end
      if (r == 2) check("wr_eq_not_new", 32'(newHigh), 0);
      if (r == 15) check("wr_count15", 32'(gameCount), 15);
    end
    check("wr_count_wrap", 32'(gameCount), 0);
    check("wr_new16", 32'(newHigh), 0);
    check("wr_high16", 32'(highScore), 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL provide parameter GAME_SECONDS, default 30, round length in seconds (legal 1..63).
REQ-002 SHALL provide parameter ACK_CYCLES, default 8, clocks to wait for endGame after timeout (legal 1..255).
REQ-003 SHALL provide port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port startIn  input  1  one-clock start pulse from the debounced push-button.
REQ-006 SHALL provide port secTick  input  1  one-clock pulse once per second from the one-second timer.
REQ-007 SHALL provide port endGame  input  1  round-complete level from memory_game.
REQ-008 SHALL provide port scoreIn  input  4  current score from memory_game.
REQ-009 SHALL provide port gameEnable  output  1  enable to memory_game.
REQ-010 SHALL provide port gameTimeout  output  1  timeout to memory_game.
REQ-011 SHALL provide port timeLeft  output  6  seconds remaining.
REQ-012 SHALL provide port finalScore  output  4  score latched at round end.
REQ-013 SHALL provide port highScore  output  4  best finalScore since reset.
REQ-014 SHALL provide port newHigh  output  1  last round set a new high score.
REQ-015 SHALL provide port gameCount  output  4  completed rounds, modulo 16.

Function
REQ-016 SHALL implement states IDLE, RUN, TIMEOUT, DONE; all outputs registered.
REQ-017 IDLE: gameEnable=0, gameTimeout=0; startIn -> RUN with timeLeft loaded to GAME_SECONDS, newHigh cleared.
REQ-018 Latency: startIn sampled at edge k -> gameEnable=1 from edge k onward (visible the following cycle).
REQ-019 RUN: gameEnable=1, gameTimeout=0; each secTick decrements timeLeft by 1.
REQ-020 RUN: secTick with timeLeft=1 -> timeLeft=0, go TIMEOUT, gameTimeout=1.
REQ-021 RUN: endGame=1 -> DONE; endGame has priority over a same-cycle secTick (no decrement, no TIMEOUT).
REQ-022 TIMEOUT: gameEnable=1, gameTimeout=1, internal wait counter counts clocks from 0.
REQ-023 TIMEOUT: endGame=1 -> DONE; if endGame is absent for ACK_CYCLES clocks -> DONE anyway (watchdog).
REQ-024 Entry into DONE: finalScore <= scoreIn sampled on the transition edge; gameCount increments, 15 wraps to 0.
REQ-025 Entry into DONE: if scoreIn > highScore (unsigned 4-bit), highScore <= scoreIn and newHigh <= 1, else newHigh <= 0; equal score is not a new high.
REQ-026 DONE: gameEnable=0, gameTimeout=0; timeLeft, finalScore, highScore, newHigh held.
REQ-027 DONE: startIn -> RUN per REQ-017 (reload timeLeft, clear newHigh); highScore retained.
REQ-028 startIn SHALL be ignored in RUN and TIMEOUT; secTick ignored in IDLE, TIMEOUT, DONE.
REQ-029 timeLeft SHALL never underflow below 0 nor wrap.
REQ-030 endGame in IDLE or DONE SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, gameEnable=0, gameTimeout=0, timeLeft=GAME_SECONDS, finalScore=0, highScore=0, newHigh=0, gameCount=0, wait counter=0, regardless of clock.
REQ-032 Reset mid-round SHALL discard the round: no gameCount increment, no highScore update.
REQ-033 After rst returns high, first state change SHALL occur no earlier than the next rising clk edge.

Verification
REQ-034 Normal end: start, 5 secTicks, endGame with scoreIn=7 -> DONE, timeLeft=25, finalScore=7, highScore=7, newHigh=1, gameCount=1, gameEnable=0.
REQ-035 Timeout (GAME_SECONDS=3): start, 3 secTicks -> gameTimeout=1, timeLeft=0; endGame 2 clocks later, scoreIn=2 with highScore=7 -> finalScore=2, highScore=7, newHigh=0.
REQ-036 Watchdog: reach TIMEOUT, hold endGame=0 for ACK_CYCLES=8 clocks, scoreIn=4 -> DONE on 8th clock, finalScore=4, gameTimeout=0.
REQ-037 Collision: in RUN with timeLeft=1, endGame and secTick same cycle -> DONE, timeLeft=1, gameTimeout never asserted.
REQ-038 Ignore/reset: startIn pulse during RUN leaves timeLeft unchanged; rst=0 mid-RUN -> all outputs per REQ-031 before next edge, gameCount=0.
REQ-039 Wrap: 16 completed rounds from reset -> gameCount=0; scoreIn=15 after highScore=15 -> newHigh=0.
